rv32i_dmem_arbiter: RTL

Shares the single-port-per-side data memory (dp_ram, unregistered output, one-cycle read latency) between the RV32I core data bus and the Avalon CSR host data-memory window. The core has priority, with a bounded-wait guarantee for the host. The block also generates the core's dwaitrequest, and it supplies real host read data to the CSR decoder's dmem readdata input. It sits between rv32i_cpu_core, core_csr_decode and the dmem instance inside core.

---
 rtl/rv32i_dmem_arbiter_if.sv | 44 ++++
 rtl/rv32i_dmem_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/rv32i_dmem_arbiter_if.sv
// Bus bundle between the core data port, the host dmem window and the shared
// single-port data memory.
interface rv32i_dmem_arbiter_if #(
   parameter int ADDR_WIDTH = 12
);
   logic [31:0]           cpu_address;
   logic                  cpu_write;
   logic [31:0]           cpu_writedata;
   logic [3:0]            cpu_byteenable;
   logic                  cpu_read;
   logic [31:0]           cpu_readdata;
   logic                  cpu_waitrequest;

   logic [ADDR_WIDTH-1:0] host_address;
   logic                  host_write;
   logic [31:0]           host_writedata;
   logic                  host_read;
   logic [31:0]           host_readdata;
   logic                  host_waitrequest;

   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_wr;
   logic [3:0]            mem_be;
   logic [31:0]           mem_wdata;
   logic [31:0]           mem_rdata;

   // Arbiter side.
   modport slave (
      input  cpu_address, cpu_write, cpu_writedata, cpu_byteenable, cpu_read,
      input  host_address, host_write, host_writedata, host_read,
      input  mem_rdata,
      output cpu_readdata, cpu_waitrequest, host_readdata, host_waitrequest,
      output mem_addr, mem_wr, mem_be, mem_wdata
   );

   // Requesters and memory side.
   modport master (
      output cpu_address, cpu_write, cpu_writedata, cpu_byteenable, cpu_read,
      output host_address, host_write, host_writedata, host_read,
      output mem_rdata,
      input  cpu_readdata, cpu_waitrequest, host_readdata, host_waitrequest,
      input  mem_addr, mem_wr, mem_be, mem_wdata
   );
endinterface

// File: rtl/rv32i_dmem_arbiter.sv
// Core-priority arbiter for the shared data memory, with a bounded-wait
// promotion for the host and two-cycle reads through a one-cycle-latency RAM.
module rv32i_dmem_arbiter #(
   parameter int ADDR_WIDTH    = 12,
   parameter int HOST_MAX_WAIT = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   rv32i_dmem_arbiter_if.slave  bus,
   output logic [15:0]          conflict_count
);
   typedef enum logic [1:0] {IDLE, RD_CPU, RD_HOST} state_t;

   localparam logic [7:0] MAX_WAIT = 8'(HOST_MAX_WAIT);

   state_t                state_reg, state_next;
   logic [7:0]            wait_cnt_reg, wait_cnt_next;
   logic [15:0]           conflict_reg, conflict_next;
   logic                  cpu_req, host_req, host_prio;
   logic                  grant_cpu, grant_host, host_served;
   logic [ADDR_WIDTH-1:0] cpu_word;
   logic                  unused_addr_bits;

   assign cpu_req   = bus.cpu_read | bus.cpu_write;
   assign host_req  = bus.host_read | bus.host_write;
   assign cpu_word  = bus.cpu_address[ADDR_WIDTH+1:2];
   assign host_prio = (wait_cnt_reg == MAX_WAIT);
   assign unused_addr_bits = ^{bus.cpu_address[31:ADDR_WIDTH+2], bus.cpu_address[1:0]};

   // Host only beats a requesting core once it has waited its full allowance.
   assign grant_host  = (state_reg == IDLE) && host_req && (host_prio || !cpu_req);
   assign grant_cpu   = (state_reg == IDLE) && cpu_req && !grant_host;
   assign host_served = grant_host || (state_reg == RD_HOST);

   always_comb begin
      state_next           = state_reg;
      bus.mem_addr         = cpu_word;
      bus.mem_wr           = 1'b0;
      bus.mem_be           = 4'h0;
      bus.mem_wdata        = bus.cpu_writedata;
      bus.cpu_waitrequest  = cpu_req;
      bus.host_waitrequest = host_req;
      bus.cpu_readdata     = bus.mem_rdata;
      bus.host_readdata    = bus.mem_rdata;

      case (state_reg)
         IDLE: begin
            if (grant_host) begin
               bus.mem_addr = bus.host_address;
               if (bus.host_write) begin
                  bus.mem_wr           = 1'b1;
                  bus.mem_be           = 4'hF;
                  bus.mem_wdata        = bus.host_writedata;
                  bus.host_waitrequest = 1'b0;
               end else begin
                  state_next = RD_HOST;
               end
            end else if (grant_cpu) begin
               if (bus.cpu_write) begin
                  bus.mem_wr          = 1'b1;
                  bus.mem_be          = bus.cpu_byteenable;
                  bus.cpu_waitrequest = 1'b0;
               end else begin
                  state_next = RD_CPU;
               end
            end
         end
         RD_CPU: begin
            bus.cpu_waitrequest  = 1'b0;
            bus.host_waitrequest = 1'b1;
            state_next           = IDLE;
         end
         RD_HOST: begin
            bus.mem_addr         = bus.host_address;
            bus.host_waitrequest = 1'b0;
            bus.cpu_waitrequest  = 1'b1;
            state_next           = IDLE;
         end
         default: state_next = IDLE;
      endcase

      // Reset silences the memory and stalls both sides, aborting any read.
      if (reset) begin
         state_next           = IDLE;
         bus.mem_wr           = 1'b0;
         bus.mem_be           = 4'h0;
         bus.cpu_waitrequest  = 1'b1;
         bus.host_waitrequest = 1'b1;
         bus.cpu_readdata     = 32'h0;
         bus.host_readdata    = 32'h0;
      end
   end

   always_comb begin
      wait_cnt_next = wait_cnt_reg;
      if (!host_req || host_served)
         wait_cnt_next = 8'h0;
      else if (wait_cnt_reg < MAX_WAIT)
         wait_cnt_next = wait_cnt_reg + 8'h1;

      conflict_next = conflict_reg;
      if ((state_reg == IDLE) && cpu_req && host_req && (conflict_reg != 16'hFFFF))
         conflict_next = conflict_reg + 16'h1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         wait_cnt_reg <= 8'h0;
         conflict_reg <= 16'h0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
         conflict_reg <= conflict_next;
      end
   end

   assign conflict_count = conflict_reg;
endmodule
